// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding, the registered
// handshake-output bundle and the per-state decode of that bundle.
package program_loader_pkg;

  // Cycles each handshake level (setup, strobe high, release low) is held.
  localparam int unsigned HoldCyclesDefault = 2;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StGetByte   = 4'd1,
    StAddrSet   = 4'd2,
    StAddrPulse = 4'd3,
    StAddrRel   = 4'd4,
    StDataSet   = 4'd5,
    StDataPulse = 4'd6,
    StDataRel   = 4'd7,
    StExecWait  = 4'd8,
    StExecPulse = 4'd9,
    StExecRel   = 4'd10,
    StRun       = 4'd11,
    StInGet     = 4'd12,
    StInSet     = 4'd13,
    StInPulse   = 4'd14,
    StInRel     = 4'd15
  } ldr_state_e;

  typedef struct packed {
    logic rx_ready;
    logic load_addr;
    logic load_data;
    logic execute;
    logic input_taken;
  } ldr_ctrl_t;

  // Level outputs belonging to a state; registered from the next state so
  // they change on the same edge as the state and never glitch.
  function automatic ldr_ctrl_t ctrl_for(ldr_state_e st);
    ldr_ctrl_t c;
    c = '0;
    case (st)
      StIdle, StGetByte, StInGet: c.rx_ready    = 1'b1;
      StAddrPulse:                c.load_addr   = 1'b1;
      StDataPulse:                c.load_data   = 1'b1;
      StExecPulse:                c.execute     = 1'b1;
      StInPulse:                  c.input_taken = 1'b1;
      default:                    c           = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Stream input plus cpu button-style handshake bundle.
//   rx_valid/rx_data/rx_ready : byte stream (transfer = valid & ready)
//   cpu_waiting/cpu_take      : cpu status (o_waiting / o_take_input)
//   load_addr/load_data/execute/input_taken/data_in : drives to cpu
// master = loader side, slave = stream source / cpu side.
interface program_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       cpu_waiting;
  logic       cpu_take;
  logic       load_addr;
  logic       load_data;
  logic       execute;
  logic       input_taken;
  logic [7:0] data_in;

  modport master (
    input  rx_valid, rx_data, cpu_waiting, cpu_take,
    output rx_ready, load_addr, load_data, execute, input_taken, data_in
  );

  modport slave (
    output rx_valid, rx_data, cpu_waiting, cpu_take,
    input  rx_ready, load_addr, load_data, execute, input_taken, data_in
  );
endinterface

// File: rtl/program_loader_hold_timer.sv
// Hold timer: measures how long the current interval has lasted.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : high in the first cycle of a new interval
//   o_done         : high in the HoldCycles-th cycle of the interval
module program_loader_hold_timer #(
  parameter int unsigned HoldCycles = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_done
);

  localparam logic [15:0] HoldCnt = 16'(HoldCycles);

  logic [15:0] count_q;
  logic [15:0] elapsed;

  // Cycles elapsed including the current one; saturates during long waits.
  always_comb begin
    if (i_start) begin
      elapsed = 16'd1;
    end else if (count_q == 16'hffff) begin
      elapsed = count_q;
    end else begin
      elapsed = count_q + 16'd1;
    end
  end

  assign o_done = (elapsed >= HoldCnt);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= elapsed;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: turns a byte stream (length N, N program bytes, then WRIM
// input bytes) into cpu load/execute/input handshakes, and re-arms on HALT.
//   i_clk, i_reset : clock shared with cpu, synchronous active-high reset
//   bus            : stream + cpu handshake bundle (master side)
//   o_busy         : high in every state except idle
//   o_halted       : one-cycle pulse when a run ends on HALT
module program_loader import program_loader_pkg::*; #(
  parameter int unsigned HoldCycles = HoldCyclesDefault
) (
  input  logic             i_clk,
  input  logic             i_reset,
  program_loader_if.master bus,
  output logic             o_busy,
  output logic             o_halted
);

  ldr_state_e state_q, state_d;
  ldr_ctrl_t  ctrl_q;
  logic [7:0] addr_q, addr_d, len_q, len_d, byte_q, byte_d, data_q, data_d;
  logic [7:0] addr_inc;
  logic [1:0] age_q, age_d;
  logic       start_q, start_d, halted_q, halted_d;
  logic       hold_done, xfer, addr_ok;

  assign xfer     = bus.rx_valid & ctrl_q.rx_ready;
  // cpu idling without an input request: address-load mode, or HALT in a run.
  assign addr_ok  = bus.cpu_waiting & ~bus.cpu_take;
  assign addr_inc = addr_q + 8'd1;

  program_loader_hold_timer #(
    .HoldCycles(HoldCycles)
  ) u_hold_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_start(start_q),
    .o_done (hold_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    byte_d   = byte_q;
    data_d   = data_q;
    halted_d = 1'b0;
    unique case (state_q)
      StIdle: if (xfer) begin
        len_d   = bus.rx_data;
        addr_d  = 8'd0;
        state_d = (bus.rx_data == 8'd0) ? StExecWait : StGetByte;
      end
      StGetByte: if (xfer) begin
        byte_d  = bus.rx_data;
        data_d  = addr_q;
        state_d = StAddrSet;
      end
      StAddrSet:   if (addr_ok && hold_done) state_d = StAddrPulse;
      StAddrPulse: if (hold_done) state_d = StAddrRel;
      StAddrRel: if (hold_done) begin
        data_d  = byte_q;
        state_d = StDataSet;
      end
      StDataSet:   if (hold_done) state_d = StDataPulse;
      StDataPulse: if (hold_done) state_d = StDataRel;
      StDataRel: if (hold_done) begin
        addr_d  = addr_inc;
        state_d = (addr_inc == len_q) ? StExecWait : StGetByte;
      end
      StExecWait:  if (bus.cpu_waiting) state_d = StExecPulse;
      StExecPulse: if (hold_done) state_d = StExecRel;
      StExecRel:   if (hold_done) state_d = StRun;
      StRun: begin
        if (bus.cpu_waiting && bus.cpu_take) begin
          state_d = StInGet;
        end else if (addr_ok && (age_q == 2'd2)) begin
          halted_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StInGet: if (xfer) begin
        data_d  = bus.rx_data;
        state_d = StInSet;
      end
      StInSet:   if (hold_done) state_d = StInPulse;
      StInPulse: if (hold_done) state_d = StInRel;
      StInRel:   if (hold_done) state_d = StRun;
      default:   state_d = StIdle;
    endcase

    // Restart the hold interval on every state change; in address setup it
    // only starts counting once the cpu is ready for an address.
    start_d = (state_d != state_q) || ((state_q == StAddrSet) && !addr_ok);

    // Run age masks HALT for the first two cycles after entering a run.
    if ((state_d != StRun) || (state_q != StRun)) begin
      age_d = 2'd0;
    end else if (age_q == 2'd2) begin
      age_d = age_q;
    end else begin
      age_d = age_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      byte_q   <= '0;
      data_q   <= '0;
      age_q    <= '0;
      start_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_for(state_d);
      addr_q   <= addr_d;
      len_q    <= len_d;
      byte_q   <= byte_d;
      data_q   <= data_d;
      age_q    <= age_d;
      start_q  <= start_d;
      halted_q <= halted_d;
    end
  end

  assign bus.rx_ready    = ctrl_q.rx_ready;
  assign bus.load_addr   = ctrl_q.load_addr;
  assign bus.load_data   = ctrl_q.load_data;
  assign bus.execute     = ctrl_q.execute;
  assign bus.input_taken = ctrl_q.input_taken;
  assign bus.data_in     = data_q;
  assign o_busy          = (state_q != StIdle);
  assign o_halted        = halted_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned Hold = 3;
  localparam int Budget = 400;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic o_busy, o_halted;

  program_loader_if bus();

  program_loader #(
    .HoldCycles(Hold)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  // Minimal cpu-side model: latches the address on load_addr, writes RAM on
  // load_data, captures input bytes, and measures strobe widths.
  logic [7:0] ram [256];
  logic [7:0] addr_l;
  logic [7:0] in_data;
  int run_len [4] = '{default: 0};
  int pulses  [4] = '{default: 0};  // 0 load_addr, 1 load_data, 2 execute, 3 input_taken
  logic [3:0] prev_lv = 4'b0000;
  int bad_width = 0;
  int halts = 0;

  always @(negedge i_clk) begin
    logic [3:0] lv;
    lv = {bus.input_taken, bus.execute, bus.load_data, bus.load_addr};
    if (bus.load_addr === 1'b1) addr_l = bus.data_in;
    if (bus.load_data === 1'b1) ram[addr_l] = bus.data_in;
    if (bus.input_taken === 1'b1) in_data = bus.data_in;
    if (o_halted === 1'b1) halts++;
    for (int k = 0; k < 4; k++) begin
      if (lv[k] === 1'b1) begin
        run_len[k]++;
      end else if (prev_lv[k] === 1'b1) begin
        if (i_reset !== 1'b1) begin
          pulses[k]++;
          if (run_len[k] != Hold) bad_width++;
        end
        run_len[k] = 0;
      end
    end
    prev_lv = lv;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic strobe(input int sel);
    logic [3:0] v;
    v = {bus.input_taken, bus.execute, bus.load_data, bus.load_addr};
    return v[sel];
  endfunction

  task automatic send_byte(input logic [7:0] b, input string tag);
    int n;
    n = 0;
    @(negedge i_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < Budget) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, (n < Budget) ? 32'd1 : 32'd0, 32'd1);
    @(posedge i_clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic wait_high(input int sel, input string tag);
    int n;
    n = 0;
    @(negedge i_clk);
    while (strobe(sel) !== 1'b1 && n < Budget) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, (n < Budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // cpu runs a while (not waiting), then halts; expects the halt pulse.
  task automatic run_then_halt(input int target, input string tag);
    int n;
    repeat (8) @(negedge i_clk);
    check({tag, "_busy"}, o_busy, 1);
    bus.cpu_waiting = 1'b1;
    bus.cpu_take    = 1'b0;
    n = 0;
    do begin
      @(negedge i_clk);
      #1 n++;
    end while (halts < target && n < Budget);
    repeat (2) @(negedge i_clk);
    #1 check({tag, "_halts"}, halts, target);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    int ready_hi;
    int n;
    for (int a = 0; a < 256; a++) ram[a] = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.cpu_waiting = 1'b0;
    bus.cpu_take = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_strobes", {bus.load_addr, bus.load_data, bus.execute, bus.input_taken}, 0);
    check("rst_data_in", bus.data_in, 8'h00);
    check("rst_busy_halted", {o_busy, o_halted}, 0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1 check("idle_rx_ready", bus.rx_ready, 1);

    // Stream {03,06,00,00}
    bus.cpu_waiting = 1'b1;
    bus.cpu_take = 1'b0;
    send_byte(8'h03, "t1_len");
    send_byte(8'h06, "t1_b0");
    send_byte(8'h00, "t1_b1");
    send_byte(8'h00, "t1_b2");
    wait_high(2, "t1_exec");
    bus.cpu_waiting = 1'b0;
    run_then_halt(1, "t1");
    check("t1_ram0", ram[0], 8'h06);
    check("t1_ram1", ram[1], 8'h00);
    check("t1_ram2", ram[2], 8'h00);
    check("t1_la_pulses", pulses[0], 3);
    check("t1_ld_pulses", pulses[1], 3);
    check("t1_ex_pulses", pulses[2], 1);
    check("t1_rx_ready", bus.rx_ready, 1);

    // Stream {00}; cpu stays waiting into the first run cycle, HALT must be masked
    bus.cpu_waiting = 1'b1;
    send_byte(8'h00, "t2_len");
    wait_high(2, "t2_exec");
    n = 0;
    while (bus.execute === 1'b1 && n < Budget) begin
      @(negedge i_clk);
      n++;
    end
    repeat (Hold + 1) @(negedge i_clk);
    bus.cpu_waiting = 1'b0;
    repeat (3) @(negedge i_clk);
    #1 check("t2_halt_masked", halts, 1);
    run_then_halt(2, "t2");
    check("t2_la_pulses", pulses[0], 3);
    check("t2_ex_pulses", pulses[2], 2);

    // WRIM program {03,02,10,00}, input byte 5A stalls during run
    bus.cpu_waiting = 1'b1;
    send_byte(8'h03, "t3_len");
    send_byte(8'h02, "t3_b0");
    send_byte(8'h10, "t3_b1");
    send_byte(8'h00, "t3_b2");
    wait_high(2, "t3_exec");
    bus.cpu_waiting = 1'b0;
    repeat (Hold + 4) @(negedge i_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h5a;
    ready_hi = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (bus.rx_ready === 1'b1) ready_hi++;
    end
    check("t3_ready_in_run", ready_hi, 0);
    bus.cpu_waiting = 1'b1;
    bus.cpu_take = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < Budget) begin
      @(negedge i_clk);
      n++;
    end
    check("t3_in_get", (n < Budget) ? 32'd1 : 32'd0, 32'd1);
    @(posedge i_clk);
    #1 bus.rx_valid = 1'b0;
    wait_high(3, "t3_input_taken");
    bus.cpu_waiting = 1'b0;
    bus.cpu_take = 1'b0;
    run_then_halt(3, "t3");
    check("t3_in_data", in_data, 8'h5a);
    check("t3_in_pulses", pulses[3], 1);
    check("t3_ram0", ram[0], 8'h02);
    check("t3_ram1", ram[1], 8'h10);
    check("t3_la_pulses", pulses[0], 6);

    // Reset during a load_data strobe, then a fresh stream {01,77}
    bus.cpu_waiting = 1'b1;
    send_byte(8'h02, "t4_len");
    send_byte(8'h11, "t4_b0");
    wait_high(1, "t4_ld");
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("t4_rx_ready", bus.rx_ready, 0);
    check("t4_strobes", {bus.load_addr, bus.load_data, bus.execute, bus.input_taken}, 0);
    check("t4_data_in", bus.data_in, 8'h00);
    check("t4_busy", o_busy, 0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    send_byte(8'h01, "t4_len2");
    send_byte(8'h77, "t4_b0_2");
    wait_high(2, "t4_exec");
    bus.cpu_waiting = 1'b0;
    run_then_halt(4, "t4");
    check("t4_ram0", ram[0], 8'h77);
    check("t4_la_pulses", pulses[0], 8);
    check("t4_ld_pulses", pulses[1], 7);
    check("t4_ex_pulses", pulses[2], 4);

    check("pulse_widths", bad_width, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
